// File: rtl/hex_sequencer.sv
// Message buffer and stepping stage feeding a seven-segment hex decoder.
// Symbols are appended one at a time and replayed in a loop at a prescaled rate.
module hex_sequencer #(
   parameter int DEPTH     = 8,
   parameter int DIV_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [3:0]               wr_data,
   input  logic                     play,
   output logic [3:0]               hex,
   output logic                     blank,
   output logic [$clog2(DEPTH)-1:0] index,
   output logic                     wrap
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);

   localparam logic [1:0] MODE_EMPTY = 2'd0;
   localparam logic [1:0] MODE_HOLD  = 2'd1;
   localparam logic [1:0] MODE_PLAY  = 2'd2;

   logic [3:0]           mem_q [DEPTH];
   logic [LW-1:0]        len_q, len_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [3:0]           hex_q, hex_d;
   logic                 blank_q, blank_d;
   logic                 wrap_q, wrap_d;
   logic [1:0]           mode_s;
   logic                 tick_s;
   logic                 wr_ok_s;
   logic                 at_last_s;

   // Operating mode is a pure function of buffer occupancy and the play level.
   always_comb begin
      mode_s = MODE_EMPTY;
      if (len_q == {LW{1'b0}}) begin
         mode_s = MODE_EMPTY;
      end else if (play) begin
         mode_s = MODE_PLAY;
      end else begin
         mode_s = MODE_HOLD;
      end
   end

   // The last-slot test uses the length before any same-cycle append.
   assign at_last_s = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));

   // Next-state for prescaler, read pointer, length and wrap flag; clear overrides all.
   always_comb begin
      div_d    = div_q;
      tick_s   = 1'b0;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      wrap_d   = 1'b0;
      wr_ok_s  = 1'b0;
      case (mode_s)
         MODE_EMPTY: div_d = {DIV_WIDTH{1'b0}};
         MODE_HOLD:  div_d = div_q;
         MODE_PLAY: begin
            div_d  = div_q + DIV_WIDTH'(1);
            tick_s = (div_q == {DIV_WIDTH{1'b1}});
         end
         default:    div_d = {DIV_WIDTH{1'b0}};
      endcase
      if (tick_s) begin
         if (at_last_s) begin
            rd_ptr_d = {PW{1'b0}};
            wrap_d   = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wrap_d   = 1'b0;
         end
      end else begin
         rd_ptr_d = rd_ptr_q;
         wrap_d   = 1'b0;
      end
      if (wr_en && (len_q < LEN_FULL)) begin
         wr_ok_s = 1'b1;
         len_d   = len_q + LW'(1);
      end else begin
         wr_ok_s = 1'b0;
         len_d   = len_q;
      end
      if (clear) begin
         div_d    = {DIV_WIDTH{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         len_d    = {LW{1'b0}};
         wrap_d   = 1'b0;
         wr_ok_s  = 1'b0;
      end else begin
         div_d = div_d;
      end
   end

   // Displayed symbol sees a same-edge write landing on the next read slot.
   always_comb begin
      hex_d   = mem_q[rd_ptr_d];
      blank_d = (len_d == {LW{1'b0}});
      if (wr_ok_s && (len_q[PW-1:0] == rd_ptr_d)) begin
         hex_d = wr_data;
      end else begin
         hex_d = mem_q[rd_ptr_d];
      end
   end

   // Message storage; appended at the current length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 4'h0;
         end
      end else if (wr_ok_s) begin
         mem_q[len_q[PW-1:0]] <= wr_data;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= {LW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         div_q    <= {DIV_WIDTH{1'b0}};
         hex_q    <= 4'h0;
         blank_q  <= 1'b1;
         wrap_q   <= 1'b0;
      end else begin
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         div_q    <= div_d;
         hex_q    <= hex_d;
         blank_q  <= blank_d;
         wrap_q   <= wrap_d;
      end
   end

   assign hex   = hex_q;
   assign blank = blank_q;
   assign index = rd_ptr_q;
   assign wrap  = wrap_q;

endmodule

// File: doc/hex_sequencer.md
# hex_sequencer

Message-buffer and stepping stage that sits directly upstream of the seven-segment hex decoder. Stores up to DEPTH 4-bit symbols written one at a time, then presents them one by one on a hex nibble output at a fixed prescaled rate, looping through the message. The decoder consumes `hex` directly; `blank` tells the display path to turn all segments off.

## Interface
- DEPTH, 8: message buffer capacity in nibbles; power of two, 2..16.
- DIV_WIDTH, 12: prescaler width; one symbol step every 2^DIV_WIDTH clocks while playing.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous message clear, 1-cycle or level.
- wr_en  input  1  append `wr_data` to the message this cycle.
- wr_data  input  4  symbol to append.
- play  input  1  level: 1 = step through message, 0 = freeze on current symbol.
- hex  output  4  current symbol, to the decoder `hex` input.
- blank  output  1  1 = message empty, display should be dark.
- index  output  $clog2(DEPTH)  buffer slot currently shown.
- wrap  output  1  1-cycle pulse when `index` returns to 0 from the last slot.

## Operation
- Storage: mem[0..DEPTH-1] × 4 bits; `len` counter 0..DEPTH (width $clog2(DEPTH)+1); `rd_ptr` = `index`; prescaler `div` of DIV_WIDTH bits.
- Modes, derived each cycle: EMPTY (len==0), HOLD (len>0, play==0), PLAY (len>0, play==1).
- Priority per edge: clear > (write, step).
- clear: len←0, rd_ptr←0, div←0; a same-cycle wr_en is discarded; mem contents not cleared.
- Write: if wr_en and len<DEPTH, mem[len]←wr_data, len←len+1. If len==DEPTH, write dropped silently, no state change.
- Prescaler: in PLAY, div←div+1 (wraps naturally); tick = PLAY && div==all-ones. In EMPTY, div←0. In HOLD, div holds its value.
- Step on tick: if rd_ptr==len-1 (len before any same-cycle write), rd_ptr←0 and wrap asserted; else rd_ptr←rd_ptr+1.
- Write and step in the same cycle both take effect; the new symbol becomes reachable on the following pass if it lands beyond rd_ptr.
- len==1 in PLAY: every tick wraps; hex constant.

## Timing
- All outputs are registers loaded from next-state values: they change on the same clk edge that updates len/rd_ptr/mem.
- hex = mem[next rd_ptr] (including a same-edge write to that slot); blank = (next len==0); index = next rd_ptr; wrap = 1 only on the edge that steps rd_ptr to 0 from len-1, 0 otherwise.
- First write to an empty buffer: blank falls and hex = wr_data on that edge.
- In PLAY each symbol is held exactly 2^DIV_WIDTH cycles; after entering PLAY from EMPTY (div=0), the first step occurs on the 2^DIV_WIDTH-th PLAY cycle.
- Reset (rst_n low, asynchronous, any time incl. mid-play): hex=0, blank=1, index=0, wrap=0, len=0, rd_ptr=0, div=0. Inputs are ignored while rst_n is low; normal operation resumes on the first edge after release.
- clear: blank=1, index=0, hex=mem[0] (don't-care while blank), wrap=0 on that edge.

## Test plan
- Reset: assert rst_n low mid-PLAY asynchronously -> outputs go to hex=0, blank=1, index=0, wrap=0 immediately; wr_en pulses while rst_n low leave blank=1 after release.
- Basic loop (DIV_WIDTH=2, DEPTH=8): write A,5,F then play=1 -> hex A for 4 cycles, 5 for 4, F for 4, then A with wrap=1 for exactly 1 cycle; index 0,1,2,0.
- Overflow (DEPTH=8): write 0..8 (nine nibbles) -> len stays 8, symbol 8 dropped; playback cycles 0..7, wrap every 32 cycles at DIV_WIDTH=2.
- Pause: DIV_WIDTH=3, drop play after 5 PLAY cycles on a symbol, hold 10 cycles, raise play -> current symbol held throughout, next step after exactly 3 more PLAY cycles.
- Clear collision: during PLAY assert clear and wr_en (data 7) together -> blank=1, index=0, wrap=0, len=0; next single write of 7 -> blank=0, hex=7.
- Single symbol / simultaneous write: len=1 in PLAY -> wrap pulses every 2^DIV_WIDTH cycles, hex constant; wr_en on the tick edge -> wrap still asserted (compare uses old len), index=0, new symbol shown on the next step.
